// File: rtl/ddr_word_sequencer_if.sv
// Handshake/status bundle between the HDR engine side and ddr_word_sequencer.
// The master modport is the engine/datapath side; the slave modport is the sequencer.
`timescale 1ns/1ps
interface ddr_word_sequencer_if #(
  parameter int WCNT_W = 8
);
  logic              i_scl_pos_edge;
  logic              i_scl_neg_edge;
  logic              i_start;
  logic [WCNT_W-1:0] i_word_count;
  logic              i_data_valid;
  logic              i_abort;
  logic              o_bitcnt_en;
  logic              o_cccnt_err_rst;
  logic [2:0]        o_phase;
  logic [5:0]        o_edge_idx;
  logic [WCNT_W-1:0] o_word_idx;
  logic              o_data_req;
  logic              o_busy;
  logic              o_done;
  logic              o_underrun;
  logic              o_err_done;

  modport master (
    output i_scl_pos_edge, i_scl_neg_edge, i_start, i_word_count, i_data_valid, i_abort,
    input  o_bitcnt_en, o_cccnt_err_rst, o_phase, o_edge_idx, o_word_idx,
    input  o_data_req, o_busy, o_done, o_underrun, o_err_done
  );

  modport slave (
    input  i_scl_pos_edge, i_scl_neg_edge, i_start, i_word_count, i_data_valid, i_abort,
    output o_bitcnt_en, o_cccnt_err_rst, o_phase, o_edge_idx, o_word_idx,
    output o_data_req, o_busy, o_done, o_underrun, o_err_done
  );
endinterface

// File: rtl/ddr_word_sequencer.sv
// HDR-DDR word sequencer: steps the bit counter through N 20-edge words and the 38-edge error window.
// Define DDR_CRC_WORD_EN to append one CRC word (phase 4) after the last data word.
`timescale 1ns/1ps
module ddr_word_sequencer #(
  parameter int WORD_EDGES = 20,
  parameter int ERR_EDGES  = 38,
  parameter int WCNT_W     = 8
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_n,
  ddr_word_sequencer_if.slave   bus
);

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_PRE  = 3'd1;
  localparam logic [2:0] PH_DATA = 3'd2;
  localparam logic [2:0] PH_PAR  = 3'd3;
`ifdef DDR_CRC_WORD_EN
  localparam logic [2:0] PH_CRC  = 3'd4;
`endif
  localparam logic [2:0] PH_ERR  = 3'd5;

  localparam logic [5:0]        IDX_PRE_LAST  = 6'd1;
  localparam logic [5:0]        IDX_WORD_LAST = 6'(WORD_EDGES - 1);
  localparam logic [5:0]        IDX_PAR_FIRST = 6'(WORD_EDGES - 2);
  localparam logic [5:0]        IDX_ERR_LAST  = 6'(ERR_EDGES - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE      = WCNT_W'(1);

`ifdef DDR_CRC_WORD_EN
  typedef enum logic [1:0] {S_IDLE, S_WORD, S_CRC, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WORD, S_ERR} state_t;
`endif

  state_t            state_q, state_d;
  logic [5:0]        edge_idx_q, edge_idx_d;
  logic [WCNT_W-1:0] word_idx_q, word_idx_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              valid_seen_q, valid_seen_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              under_q, under_d;
  logic              err_done_q, err_done_d;
  logic [2:0]        phase_q;
  logic              bitcnt_en_q, err_rst_q, busy_q;
  logic              edge_ev;

  function automatic logic [2:0] phase_of(input state_t s, input logic [5:0] idx);
    logic [2:0] p;
    p = PH_IDLE;
    case (s)
      S_WORD: begin
        if (idx <= IDX_PRE_LAST)       p = PH_PRE;
        else if (idx < IDX_PAR_FIRST)  p = PH_DATA;
        else                           p = PH_PAR;
      end
`ifdef DDR_CRC_WORD_EN
      S_CRC:  p = PH_CRC;
`endif
      S_ERR:  p = PH_ERR;
      default: p = PH_IDLE;
    endcase
    return p;
  endfunction

  // Simultaneous pos/neg strobes collapse into a single edge event.
  assign edge_ev = bus.i_scl_pos_edge | bus.i_scl_neg_edge;

  always_comb begin
    state_d      = state_q;
    edge_idx_d   = edge_idx_q;
    word_idx_d   = word_idx_q;
    cnt_d        = cnt_q;
    valid_seen_d = valid_seen_q | bus.i_data_valid;
    req_d        = 1'b0;
    done_d       = 1'b0;
    under_d      = 1'b0;
    err_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_word_count != '0) begin
            state_d      = S_WORD;
            edge_idx_d   = '0;
            word_idx_d   = '0;
            cnt_d        = bus.i_word_count;
            req_d        = 1'b1;
            valid_seen_d = 1'b0;
          end else begin
`ifdef DDR_CRC_WORD_EN
            state_d    = S_CRC;
            edge_idx_d = '0;
`else
            done_d     = 1'b1;
`endif
          end
        end
      end
      S_WORD: begin
        if (bus.i_abort) begin
          state_d    = S_ERR;
          edge_idx_d = '0;
        end else if (edge_ev) begin
          // The word's data must have been offered by the edge leaving the preamble.
          if (edge_idx_q == IDX_PRE_LAST && !(valid_seen_q || bus.i_data_valid)) begin
            under_d    = 1'b1;
            state_d    = S_ERR;
            edge_idx_d = '0;
          end else if (edge_idx_q == IDX_WORD_LAST) begin
            edge_idx_d = '0;
            if (word_idx_q == cnt_q - WCNT_ONE) begin
              word_idx_d = '0;
`ifdef DDR_CRC_WORD_EN
              state_d    = S_CRC;
`else
              state_d    = S_IDLE;
              done_d     = 1'b1;
`endif
            end else begin
              word_idx_d   = word_idx_q + WCNT_ONE;
              req_d        = 1'b1;
              valid_seen_d = 1'b0;
            end
          end else begin
            edge_idx_d = edge_idx_q + 6'd1;
          end
        end
      end
`ifdef DDR_CRC_WORD_EN
      S_CRC: begin
        if (bus.i_abort) begin
          state_d    = S_ERR;
          edge_idx_d = '0;
        end else if (edge_ev) begin
          if (edge_idx_q == IDX_WORD_LAST) begin
            state_d    = S_IDLE;
            edge_idx_d = '0;
            done_d     = 1'b1;
          end else begin
            edge_idx_d = edge_idx_q + 6'd1;
          end
        end
      end
`endif
      S_ERR: begin
        if (edge_ev) begin
          if (edge_idx_q == IDX_ERR_LAST) begin
            state_d    = S_IDLE;
            edge_idx_d = '0;
            word_idx_d = '0;
            err_done_d = 1'b1;
          end else begin
            edge_idx_d = edge_idx_q + 6'd1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        edge_idx_d = '0;
        word_idx_d = '0;
      end
    endcase
  end

  // Status outputs are derived from next-state so they are registered with the FSM.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      edge_idx_q   <= '0;
      word_idx_q   <= '0;
      cnt_q        <= '0;
      valid_seen_q <= 1'b0;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
      under_q      <= 1'b0;
      err_done_q   <= 1'b0;
      phase_q      <= PH_IDLE;
      bitcnt_en_q  <= 1'b0;
      err_rst_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_idx_q   <= edge_idx_d;
      word_idx_q   <= word_idx_d;
      cnt_q        <= cnt_d;
      valid_seen_q <= valid_seen_d;
      req_q        <= req_d;
      done_q       <= done_d;
      under_q      <= under_d;
      err_done_q   <= err_done_d;
      phase_q      <= phase_of(state_d, edge_idx_d);
`ifdef DDR_CRC_WORD_EN
      bitcnt_en_q  <= (state_d == S_WORD) || (state_d == S_CRC);
`else
      bitcnt_en_q  <= (state_d == S_WORD);
`endif
      err_rst_q    <= (state_d == S_ERR);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign bus.o_bitcnt_en     = bitcnt_en_q;
  assign bus.o_cccnt_err_rst = err_rst_q;
  assign bus.o_phase         = phase_q;
  assign bus.o_edge_idx      = edge_idx_q;
  assign bus.o_word_idx      = word_idx_q;
  assign bus.o_data_req      = req_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_done          = done_q;
  assign bus.o_underrun      = under_q;
  assign bus.o_err_done      = err_done_q;

endmodule

// File: tb/tb_ddr_word_sequencer.sv
// Directed bench for ddr_word_sequencer: pulse outputs go through an expected-event queue,
// per-edge status is compared against hand-derived phase/index values.
`timescale 1ns/1ps
module tb_ddr_word_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ddr_word_sequencer_if #(.WCNT_W(8)) bus ();

  ddr_word_sequencer #(.WORD_EDGES(20), .ERR_EDGES(38), .WCNT_W(8)) dut (
    .i_sys_clk (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  typedef enum int {EV_REQ, EV_DONE, EV_UNDER, EV_ERRDONE} ev_kind_t;
  typedef struct {ev_kind_t kind; int widx;} ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int npulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input int w);
    ev_t e;
    e.kind = k;
    e.widx = w;
    exp_q.push_back(e);
  endtask

  task automatic take(input ev_kind_t k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %s pulse expected none", k.name());
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_REQ && e.widx != int'(bus.o_word_idx))) begin
        errors++;
        $display("FAIL sb_event: got %s word %0d expected %s word %0d",
                 k.name(), bus.o_word_idx, e.kind.name(), e.widx);
      end
    end
  endtask

  // Monitor: every pulse output is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      npulse = int'(bus.o_data_req) + int'(bus.o_done) + int'(bus.o_underrun) + int'(bus.o_err_done);
      if (npulse > 1) chk("pulse_exclusive", npulse, 1);
      if (bus.o_data_req === 1'b1) take(EV_REQ);
      if (bus.o_done     === 1'b1) take(EV_DONE);
      if (bus.o_underrun === 1'b1) take(EV_UNDER);
      if (bus.o_err_done === 1'b1) take(EV_ERRDONE);
    end
  end

  function automatic int exp_phase(input int idx);
    if (idx < 2)  return 1;
    if (idx < 18) return 2;
    return 3;
  endfunction

  task automatic edge_pulse(input bit p, input bit n, input bit ab = 1'b0);
    bus.i_scl_pos_edge = p;
    bus.i_scl_neg_edge = n;
    bus.i_abort        = ab;
    @(negedge clk);
    bus.i_scl_pos_edge = 1'b0;
    bus.i_scl_neg_edge = 1'b0;
    bus.i_abort        = 1'b0;
  endtask

  task automatic start(input int cnt);
    bus.i_start      = 1'b1;
    bus.i_word_count = 8'(cnt);
    @(negedge clk);
    bus.i_start      = 1'b0;
  endtask

  // Called right after the last data edge; covers both completion styles.
  task automatic expect_end(input string tag);
`ifdef DDR_CRC_WORD_EN
    chk({tag, "_crc_phase"}, bus.o_phase, 4);
    chk({tag, "_crc_bitcnt"}, bus.o_bitcnt_en, 1);
    for (int i = 1; i <= 20; i++) begin
      if (i == 20) push_ev(EV_DONE, 0);
      edge_pulse(1'b1, 1'b0);
    end
`endif
    chk({tag, "_done"}, bus.o_done, 1);
    chk({tag, "_busy_end"}, bus.o_busy, 0);
    chk({tag, "_phase_end"}, bus.o_phase, 0);
  endtask

  task automatic err_window(input string tag);
    for (int k = 1; k <= 38; k++) begin
      if (k == 38) push_ev(EV_ERRDONE, 0);
      edge_pulse(k[0], !k[0]);
      if (k == 37) begin
        chk({tag, "_err_idx37"}, bus.o_edge_idx, 37);
        chk({tag, "_err_done_early"}, bus.o_err_done, 0);
      end
    end
    chk({tag, "_err_done"}, bus.o_err_done, 1);
    chk({tag, "_err_busy"}, bus.o_busy, 0);
    chk({tag, "_err_rst_clr"}, bus.o_cccnt_err_rst, 0);
    @(negedge clk);
    chk({tag, "_err_done_1cyc"}, bus.o_err_done, 0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    bus.i_scl_pos_edge = 1'b0;
    bus.i_scl_neg_edge = 1'b0;
    bus.i_start        = 1'b0;
    bus.i_word_count   = '0;
    bus.i_data_valid   = 1'b0;
    bus.i_abort        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_phase", bus.o_phase, 0);
    chk("rst_bitcnt", bus.o_bitcnt_en, 0);
    chk("rst_errrst", bus.o_cccnt_err_rst, 0);
    chk("rst_edge_idx", bus.o_edge_idx, 0);
    chk("rst_pulses", {bus.o_data_req, bus.o_done, bus.o_underrun, bus.o_err_done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two words, data always valid, alternating edges; one double strobe and a busy start.
    bus.i_data_valid = 1'b1;
    push_ev(EV_REQ, 0);
    start(2);
    chk("a_busy", bus.o_busy, 1);
    chk("a_bitcnt", bus.o_bitcnt_en, 1);
    chk("a_phase0", bus.o_phase, 1);
    chk("a_idx0", bus.o_edge_idx, 0);
    for (int e = 1; e <= 40; e++) begin
      if (e == 20) push_ev(EV_REQ, 1);
`ifndef DDR_CRC_WORD_EN
      if (e == 40) push_ev(EV_DONE, 0);
`endif
      if (e == 5) begin
        bus.i_start      = 1'b1;
        bus.i_word_count = 8'd7;
      end
      edge_pulse((e % 2 == 1) || (e == 10), (e % 2 == 0));
      bus.i_start = 1'b0;
      if (e < 40) begin
        chk($sformatf("a_phase_e%0d", e), bus.o_phase, exp_phase(e % 20));
        chk($sformatf("a_idx_e%0d", e), bus.o_edge_idx, e % 20);
        chk($sformatf("a_word_e%0d", e), bus.o_word_idx, e / 20);
      end
    end
    expect_end("a");
    @(negedge clk);
    chk("a_done_1cyc", bus.o_done, 0);

    // One word, data never offered: underrun on the edge leaving the preamble.
    bus.i_data_valid = 1'b0;
    push_ev(EV_REQ, 0);
    push_ev(EV_UNDER, 0);
    start(1);
    edge_pulse(1'b1, 1'b0);
    chk("b_idx1", bus.o_edge_idx, 1);
    edge_pulse(1'b0, 1'b1);
    chk("b_underrun", bus.o_underrun, 1);
    chk("b_phase_err", bus.o_phase, 5);
    chk("b_errrst", bus.o_cccnt_err_rst, 1);
    chk("b_bitcnt", bus.o_bitcnt_en, 0);
    chk("b_idx_err0", bus.o_edge_idx, 0);
    err_window("b");

    // Abort coincident with edge 7 of word 0: abort wins, edge not counted.
    bus.i_data_valid = 1'b1;
    push_ev(EV_REQ, 0);
    start(3);
    for (int e = 1; e <= 6; e++) edge_pulse(1'b1, 1'b0);
    chk("c_idx6", bus.o_edge_idx, 6);
    edge_pulse(1'b1, 1'b0, 1'b1);
    chk("c_phase_err", bus.o_phase, 5);
    chk("c_errrst", bus.o_cccnt_err_rst, 1);
    chk("c_bitcnt", bus.o_bitcnt_en, 0);
    chk("c_idx0", bus.o_edge_idx, 0);
    err_window("c");

    // Asynchronous reset at edge 10, then a fresh transfer with late-but-legal data.
    push_ev(EV_REQ, 0);
    start(2);
    for (int e = 1; e <= 10; e++) edge_pulse(1'b0, 1'b1);
    chk("d_idx10", bus.o_edge_idx, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("d_rst_busy", bus.o_busy, 0);
    chk("d_rst_idx", bus.o_edge_idx, 0);
    chk("d_rst_phase", bus.o_phase, 0);
    chk("d_rst_bitcnt", bus.o_bitcnt_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_data_valid = 1'b0;
    @(negedge clk);
    push_ev(EV_REQ, 0);
    start(1);
    chk("d_word0", bus.o_word_idx, 0);
    chk("d_idx0", bus.o_edge_idx, 0);
    chk("d_phase_pre", bus.o_phase, 1);
    edge_pulse(1'b1, 1'b0);
    bus.i_data_valid = 1'b1;
    edge_pulse(1'b0, 1'b1);
    chk("d_late_valid_phase", bus.o_phase, 2);
    chk("d_late_valid_nounder", bus.o_underrun, 0);
    for (int e = 3; e <= 20; e++) begin
`ifndef DDR_CRC_WORD_EN
      if (e == 20) push_ev(EV_DONE, 0);
`endif
      edge_pulse(1'b1, 1'b0);
    end
    expect_end("d");

    // Zero-word transfer.
    @(negedge clk);
`ifdef DDR_CRC_WORD_EN
    start(0);
    chk("e_busy", bus.o_busy, 1);
    chk("e_req", bus.o_data_req, 0);
    expect_end("e");
`else
    push_ev(EV_DONE, 0);
    start(0);
    chk("e_done", bus.o_done, 1);
    chk("e_busy", bus.o_busy, 0);
    chk("e_bitcnt", bus.o_bitcnt_en, 0);
    @(negedge clk);
    chk("e_done_1cyc", bus.o_done, 0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_word_sequencer.md
# ddr_word_sequencer

Controller that sequences the HDR-DDR bit counter for one transfer of N 20-bit words (2 preamble, 16 data, 2 parity edges each). It drives the counter's enable and error-recovery controls, tracks the current word phase from SCL edge strobes, handshakes 16-bit data words from the frame datapath, and runs the 38-edge error-recovery window on abort or underrun. It sits between the HDR engine FSM and the bit counter / serializer.

## Interface
- WORD_EDGES, 20, SCL edges per DDR word
- ERR_EDGES, 38, SCL edges in the error-recovery window
- WCNT_W, 8, width of the word-count request
- i_sys_clk  in  1  system clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_scl_pos_edge  in  1  one-cycle SCL rising-edge strobe
- i_scl_neg_edge  in  1  one-cycle SCL falling-edge strobe
- i_start  in  1  start transfer; sampled only in IDLE
- i_word_count  in  WCNT_W  data words to send; latched on accepted i_start
- i_data_valid  in  1  next data word is ready
- i_abort  in  1  abort request
- o_bitcnt_en  out  1  bit-counter enable
- o_cccnt_err_rst  out  1  bit-counter error-recovery mode
- o_phase  out  3  0 IDLE, 1 PRE, 2 DATA, 3 PAR, 4 CRC, 5 ERR
- o_edge_idx  out  6  edge index within current word or error window
- o_word_idx  out  WCNT_W  index of current data word
- o_data_req  out  1  one-cycle request for the next data word
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse on normal completion
- o_underrun  out  1  one-cycle pulse on data underrun
- o_err_done  out  1  one-cycle pulse at end of error recovery

## Operation
- FSM states: IDLE, WORD (sub-phase PRE/DATA/PAR from edge_idx), CRC (macro only), ERR.
- Edge event = i_scl_pos_edge | i_scl_neg_edge. Both strobes high in one cycle count as one edge.
- IDLE: i_start with i_word_count != 0 -> WORD, edge_idx=0, word_idx=0, o_data_req pulse. With i_word_count == 0 -> o_done pulse, stay IDLE (macro off) or go to CRC (macro on).
- WORD: o_bitcnt_en=1. Phase is PRE for idx 0-1, DATA for 2-17, PAR for 18-19. Each edge increments edge_idx.
- An edge at idx 19 sets idx to 0. If the finished word was not the last, word_idx increments and o_data_req pulses. If it was the last, the FSM goes to CRC (macro on) or IDLE with an o_done pulse.
- Handshake: i_data_valid must be seen high in any cycle from the o_data_req pulse up to and including the cycle of the edge that moves idx 1->2. Otherwise o_underrun pulses and the FSM enters ERR.
- i_abort in WORD or CRC enters ERR on the next cycle. i_abort is ignored in IDLE and ERR.
- ERR: o_bitcnt_en=0, o_cccnt_err_rst=1, edge_idx cleared on entry, counts 0..ERR_EDGES-1. The edge at idx 37 pulses o_err_done and returns to IDLE. No o_done is issued.
- i_start is ignored while o_busy=1.

## Timing
- Reset value of every output is 0. State goes to IDLE and all counters clear. Reset mid-transfer drops all activity with no done or error pulse.
- All outputs are registered. Entry into WORD, o_bitcnt_en and the first o_data_req occur 1 cycle after the accepted i_start.
- edge_idx and phase update 1 cycle after the edge strobe.
- o_done, o_underrun and o_err_done rise 1 cycle after the causing edge or check, last exactly 1 cycle, and are mutually exclusive.
- Abort and an edge in the same cycle: abort wins and the edge is not counted.
- word_idx wraps at WCNT_W bits. The maximum transfer is 2^WCNT_W-1 words.

## Configuration
- DDR_CRC_WORD_EN defined: after the last data word, the FSM enters CRC for one WORD_EDGES window. o_phase=4, o_bitcnt_en=1, no o_data_req, no underrun check. The edge at idx 19 pulses o_done and returns to IDLE. i_abort during CRC enters ERR.
- DDR_CRC_WORD_EN undefined: CRC state and phase code 4 are absent. o_done follows the last data word directly.

## Test plan
- Start with count 2, data valid always high, 40 alternating edges -> phase sequence PRE×2, DATA×16, PAR×2 per word; o_data_req at start and after edge 20; o_done 1 cycle after edge 40.
- Count 1, i_data_valid never asserted -> o_underrun 1 cycle after edge 2; ERR for 38 edges; o_err_done after edge 38; o_done never.
- Abort at edge 7 of word 0 -> o_cccnt_err_rst=1 and o_bitcnt_en=0 next cycle; o_err_done after 38 further edges.
- Pos and neg strobes both high in one cycle -> edge_idx advances by 1. i_start while busy -> no effect.
- Assert i_rst_n low at edge 10 -> all outputs 0 asynchronously; a new start after release begins at word_idx 0, idx 0.
- DDR_CRC_WORD_EN with count 0 -> 20-edge CRC phase, then o_done. Without the macro -> o_done 1 cycle after start, no edges consumed.
